// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: output modes and the
// smallest divisor the counter can produce a meaningful period with.
package clk_div_pkg;

  localparam logic MODE_DUTY50 = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;
  localparam int   DIV_MIN     = 2;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, posedge/negedge duty generator and tick.
// Runs from the configuration currently in force (div_i/mode_i); the parent
// only changes those on a period boundary or while the core is idle.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  input  logic         mode_i,
  output logic         clk_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last_cnt;
  logic [W-1:0] hi_start;
  logic         wrap;
  logic         p_q, p_d;
  logic         n_q, n_d;
  logic         odd_duty;

  assign last_cnt = div_i - W'(1);
  assign wrap     = en_i & (cnt_q == last_cnt);

  // First count of the high phase, ceil(N/2); cannot overflow since N <= 2^W-1.
  assign hi_start = (div_i >> 1) + {{(W-1){1'b0}}, div_i[0]};

  // Only odd divisors in 50% mode need the extra half cycle from the negedge flop.
  assign odd_duty = div_i[0] & (mode_i == MODE_DUTY50);
  assign n_d      = p_q & odd_duty;

  // Next count and next posedge output level, decoded from the next count so p_q is a clean flop.
  always_comb begin
    cnt_d = '0;
    p_d   = 1'b0;
    if (en_i && !wrap) begin
      cnt_d = cnt_q + W'(1);
    end
    if (en_i) begin
      if (mode_i == MODE_PULSE) begin
        p_d = (cnt_d == last_cnt);
      end else begin
        p_d = (cnt_d >= hi_start);
      end
    end
  end

  // Counter and posedge output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  // Negedge copy of p_q, stretching the high phase by half a cycle for odd N.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      n_q <= 1'b0;
    end else begin
      n_q <= n_d;
    end
  end

  assign clk_o  = p_q | n_q;
  assign tick_o = wrap;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider. Accepts a divisor/mode pair over
// a valid/ready handshake, parks it in a pending slot, and hands it to the
// core only at a period boundary (or immediately while disabled) so the
// divided clock never glitches.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEF_DIV  = 7,
  parameter int DEF_MODE = 0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic         cfg_mode,
  output logic         cfg_err,
  output logic         busy,
  output logic         clk_out,
  output logic         tick
);

  if (DEF_DIV < DIV_MIN || DEF_DIV > (2 ** W) - 1) begin : g_bad_def_div
    $error("clk_divider_prog: DEF_DIV outside 2..2^W-1");
  end
  if (DEF_MODE != 0 && DEF_MODE != 1) begin : g_bad_def_mode
    $error("clk_divider_prog: DEF_MODE must be 0 or 1");
  end

  localparam logic [W-1:0] DEF_DIV_W  = W'(DEF_DIV);
  localparam logic         DEF_MODE_B = (DEF_MODE == 1) ? MODE_PULSE : MODE_DUTY50;

  logic [W-1:0] div_q, div_d;
  logic         mode_q, mode_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         pend_mode_q, pend_mode_d;
  logic         err_q, err_d;
  logic         wrap;
  logic         accept;
  logic         apply;

  assign accept = cfg_valid & ~pend_q;
  assign apply  = pend_q & (wrap | ~en);

  // Handshake: capture a legal request into the pending slot, flag an illegal one,
  // and move the pending slot into the active config at the boundary.
  always_comb begin
    div_d       = div_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    err_d       = 1'b0;
    if (apply) begin
      div_d  = pend_div_q;
      mode_d = pend_mode_q;
      pend_d = 1'b0;
    end else if (accept) begin
      if (cfg_div >= W'(DIV_MIN)) begin
        pend_d      = 1'b1;
        pend_div_d  = cfg_div;
        pend_mode_d = cfg_mode;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Active and pending configuration registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q       <= DEF_DIV_W;
      mode_q      <= DEF_MODE_B;
      pend_q      <= 1'b0;
      pend_div_q  <= DEF_DIV_W;
      pend_mode_q <= DEF_MODE_B;
      err_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      err_q       <= err_d;
    end
  end

  clk_div_core #(
    .W (W)
  ) u_core (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en_i      (en),
    .div_i     (div_q),
    .mode_i    (mode_q),
    .clk_o     (clk_out),
    .tick_o    (wrap)
  );

  assign tick      = wrap;
  assign cfg_ready = ~pend_q;
  assign busy      = pend_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog. A stimulus process drives one cycle at a time,
// advances a period-level reference model and pushes the expected outputs of
// that cycle into a scoreboard; a monitor samples the DUT in both clock
// halves and pops/compares.
module tb_clk_divider_prog;

  localparam int W        = 8;
  localparam int DEF_DIV  = 7;
  localparam int DEF_MODE = 0;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         en        = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div   = '0;
  logic         cfg_mode  = 1'b0;
  logic         cfg_ready, cfg_err, busy, clk_out, tick;

  always #5 sys_clk = ~sys_clk;

  clk_divider_prog #(
    .W        (W),
    .DEF_DIV  (DEF_DIV),
    .DEF_MODE (DEF_MODE)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  typedef struct {
    bit clk_a;   // clk_out in the first half of the cycle
    bit clk_b;   // clk_out in the second half
    bit tick;
    bit busy;
    bit ready;
    bit err;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  // Reference model: position within the period, active and pending config.
  int   m_ph, m_n, m_mode, m_pn, m_pm;
  bit   m_pend, m_err, m_stretch;

  // Master-side request, held until the DUT takes it.
  bit   req_v;
  int   req_div, req_mode;

  // Level of the divided clock at period position ph: pulse mode is high only in the
  // last position; 50% mode is high for the last floor(N/2) positions (odd N gets an
  // extra half cycle carried into the next position, tracked by m_stretch).
  function automatic bit level_at(int ph, int n, int mode);
    if (mode == 1) return ph == n - 1;
    return ph >= n - n / 2;
  endfunction

  task automatic model_reset();
    m_ph      = 0;
    m_n       = DEF_DIV;
    m_mode    = DEF_MODE;
    m_pend    = 0;
    m_pn      = DEF_DIV;
    m_pm      = DEF_MODE;
    m_err     = 0;
    m_stretch = 0;
  endtask

  task automatic step(input bit en_v, input bit rst_n_v);
    exp_t e;
    bit   lvl, wrap, acc;
    @(posedge sys_clk);
    #2;
    lvl     = level_at(m_ph, m_n, m_mode);
    e.clk_a = lvl | m_stretch;
    e.cyc   = cyc_no;
    sys_rst_n = rst_n_v;
    en        = en_v;
    cfg_valid = req_v;
    cfg_div   = req_div[W-1:0];
    cfg_mode  = req_mode[0];
    if (!rst_n_v) begin
      model_reset();
      e.clk_b = 0; e.tick = 0; e.busy = 0; e.ready = 1; e.err = 0;
    end else begin
      e.clk_b = lvl;
      e.tick  = en_v && (m_ph == m_n - 1);
      e.busy  = m_pend;
      e.ready = !m_pend;
      e.err   = m_err;
      wrap      = e.tick;
      acc       = req_v && !m_pend;
      m_stretch = lvl && (m_n % 2 == 1) && (m_mode == 0);
      m_err     = acc && (req_div < 2);
      if (m_pend && (wrap || !en_v)) begin
        m_n    = m_pn;
        m_mode = m_pm;
        m_pend = 0;
      end else if (acc && req_div >= 2) begin
        m_pend = 1;
        m_pn   = req_div;
        m_pm   = req_mode;
      end
      m_ph = (!en_v || wrap) ? 0 : m_ph + 1;
      if (acc) req_v = 0;
    end
    sb_q.push_back(e);
    cyc_no++;
  endtask

  function automatic void chk(string name, int cyc, logic act, bit req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endfunction

  // Monitor: sample both halves of every cycle and compare against the scoreboard.
  initial begin
    logic a;
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1 a = clk_out;
      @(negedge sys_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("clk_out_first_half", e.cyc, a, e.clk_a);
        chk("clk_out_second_half", e.cyc, clk_out, e.clk_b);
        chk("tick", e.cyc, tick, e.tick);
        chk("busy", e.cyc, busy, e.busy);
        chk("cfg_ready", e.cyc, cfg_ready, e.ready);
        chk("cfg_err", e.cyc, cfg_err, e.err);
      end
    end
  end

  initial begin
    bit en_r;
    int r, rst_left;
    model_reset();
    req_v = 0; req_div = 0; req_mode = 0;

    // Reset, then defaults: divide by 7, 50% duty.
    repeat (3) step(0, 0);
    repeat (30) step(1, 1);
    // Divisor 4 requested mid-period.
    repeat (3) step(1, 1);
    req_v = 1; req_div = 4; req_mode = 0;
    repeat (20) step(1, 1);
    // Illegal divisors 1 and 0.
    req_v = 1; req_div = 1; req_mode = 0;
    repeat (3) step(1, 1);
    req_v = 1; req_div = 0;
    repeat (10) step(1, 1);
    // Pulse mode, divide by 5.
    req_v = 1; req_div = 5; req_mode = 1;
    repeat (20) step(1, 1);
    // Back-to-back requests: the second is held off while the first is pending.
    req_v = 1; req_div = 3; req_mode = 0;
    step(1, 1);
    req_v = 1; req_div = 6; req_mode = 0;
    repeat (25) step(1, 1);
    // Enable drop with a pending config, then a reset pulse mid-period.
    req_v = 1; req_div = 9; req_mode = 0;
    repeat (2) step(1, 1);
    repeat (4) step(0, 1);
    repeat (14) step(1, 1);
    step(1, 0);
    step(1, 0);
    repeat (20) step(1, 1);

    // Randomised traffic.
    en_r = 1; rst_left = 0;
    repeat (2500) begin
      if (!req_v && $urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 8)       req_div = $urandom_range(0, 1);
        else if (r < 11) req_div = $urandom_range(200, 255);
        else             req_div = $urandom_range(2, 13);
        req_mode = $urandom_range(0, 1);
        req_v    = 1;
      end
      if (en_r ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 5) == 0)) en_r = !en_r;
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      step(en_r, rst_left == 0);
      if (rst_left > 0) rst_left--;
    end

    repeat (3) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
